vga_text_overlay: RTL and testbench
===================================

Name: vga_text_overlay

Overview:
- Pixel-generation stage directly downstream of the VGA timing generator in the POS terminal display path.
- Consumes the 25 MHz pixel tick, H/V counters and HSync/VSync from the timing stage.
- Renders an 80x30 character text screen (8x16 glyphs, 640x480 visible) from an internal text RAM that POS logic writes. Glyph bits come from an external font ROM.
- Drives the Red/Green/Blue and delayed sync outputs to the VGA connector.

Parameters:
- H_VIS_START, 144, first visible H count
- V_VIS_START, 35, first visible V count
- COLS, 80, text columns
- ROWS, 30, text rows
- INIT_CHAR, 8'h20, character code written to every cell by the clear sequencer

Ports:
- clk  in  1  system clock (100 MHz)
- rst_n  in  1  asynchronous active-low reset
- pix_en  in  1  pixel tick, one clk wide, every 4th clk (25 MHz)
- h_cnt  in  10  horizontal counter from timing stage, valid on pix_en
- v_cnt  in  10  vertical counter from timing stage, valid on pix_en
- hsync_in  in  1  HSync from timing stage (active high)
- vsync_in  in  1  VSync from timing stage (active high)
- wr_en  in  1  text RAM write strobe
- wr_addr  in  12  cell index = row*COLS+col
- wr_data  in  12  [7:0] char code, [10:8] fg colour {R,G,B}, [11] inverse
- ready  out  1  high once clear sequencer is done; writes are accepted only when high
- font_addr  out  12  {char code, glyph row[3:0]} to font ROM
- font_data  in  8  glyph row from font ROM, registered one pix_en after font_addr; bit7 = leftmost pixel
- HSync  out  1  hsync_in delayed 3 pix_en ticks
- VSync  out  1  vsync_in delayed 3 pix_en ticks
- Red/Green/Blue  out  4 each  pixel colour, 4'hF or 4'h0 per channel

Behaviour:
- Reset (async, rst_n=0): HSync=VSync=0; RGB=0; ready=0; font_addr=0; all pipeline registers cleared; FSM enters CLEAR with clear pointer 0. Reset mid-frame or mid-clear restarts CLEAR from address 0.
- FSM CLEAR:
  - One write per clk of {4'b0111, INIT_CHAR} (white, not inverse) to addresses 0..COLS*ROWS-1 (2399).
  - External writes are ignored; RGB is forced 0; syncs still pass through the delay line.
  - After address 2399 is written, moves to RUN next clk; ready=1 from that clk.
- FSM RUN: stays in RUN until reset.
- Text RAM: 2400x12 dual-port; writes on any clk (not gated by pix_en) when wr_en&ready. wr_addr>=2400 is ignored, no wrap. A same-cycle read and write to one address returns the old data.
- Pipeline (advances only on pix_en):
  - S1: x=h_cnt-H_VIS_START, y=v_cnt-V_VIS_START; vis = 0<=x<640 && 0<=y<480; RAM read at (y>>4)*80+(x>>3). Register vis, x[2:0], y[3:0].
  - S2: font_addr <= {char, y[3:0]}; register attr and x[2:0].
  - S3: bit = font_data[7-x[2:0]] XOR inverse; if vis&&bit, each channel = 4'hF when its fg bit is set, else 4'h0; otherwise all 0.
- Latency: 3 pix_en ticks from counters to RGB. HSync/VSync are delayed identically, so alignment is preserved.
- Outside the visible window: RGB=0, even with inverse set.

Optional Feature:
CURSOR_BLINK_EN.
- Defined: adds inputs cursor_en (1) and cursor_addr (12). A 5-bit frame counter increments on each rising edge of vsync_in (sampled on pix_en) and resets to 0. When counter[4]=1 and cursor_en=1, the cell at cursor_addr renders inverted (bit XOR 1), giving a blink period of 32 frames.
- Undefined: no extra ports; cursor logic and frame counter are absent.

Test Plan:
- Reset release -> ready=0 for exactly 2400 clk, then 1; a read of any cell returns 12'h720; RGB=0 throughout the first frame.
- Write addr 0 = 12'h741 ('A', white); font ROM model returns 8'h80 for row 0 -> pixel (H=144,V=35) RGB=FFF three pix_en later, (H=145,V=35) RGB=000.
- Write addr 2399 = 12'hC41 (fg R only, inverse) -> pixels in cell (79,29) show R=F, G=B=0 wherever the glyph bit is 0.
- wr_en with wr_addr=2400 or while ready=0 -> RAM contents unchanged (read-back check).
- Drive hsync_in pulse for H 0..95 -> HSync high exactly 3 pix_en later for 96 ticks; RGB=0 when H<144 or H>=784.
- CURSOR_BLINK_EN, cursor_addr=5, cursor_en=1 -> cell 5 inverted during frames 16..31, normal during frames 0..15 and 32..47.

Source files
------------

// File: rtl/vga_text_overlay.sv
// -----------------------------------------------------------------------------
// vga_text_overlay
//   Pixel-generation stage that sits behind the VGA timing generator. Renders
//   an 80x30 text screen of 8x16 glyphs (640x480 visible) from an internal
//   2400x12 text RAM. Glyph rows come from an external font ROM.
//
//   Optional feature macro: CURSOR_BLINK_EN
//     When defined, adds cursor_en / cursor_addr. A 5-bit frame counter
//     (rising edges of vsync_in on pixel ticks) inverts the cursor cell while
//     counter[4] is set, which gives a 32-frame blink period.
//
// Ports
//   clk, rst_n          100 MHz clock, asynchronous active-low reset
//   pix_en              25 MHz pixel tick (one clk wide)
//   h_cnt, v_cnt        timing counters, valid on pix_en
//   hsync_in, vsync_in  syncs from the timing stage (active high)
//   wr_en/wr_addr/wr_data  text RAM write port; wr_data = {inv, fg[2:0], char}
//   ready               high once the power-on clear of the text RAM is done
//   font_addr/font_data font ROM interface; font_data is sampled on the pixel
//                       tick after font_addr is presented (ROM latency must fit
//                       within one pixel period)
//   HSync, VSync        syncs delayed by 3 pixel ticks
//   Red, Green, Blue    4'hF / 4'h0 per channel
// -----------------------------------------------------------------------------
module vga_text_overlay #(
  parameter logic [9:0] H_VIS_START = 10'd144,
  parameter logic [9:0] V_VIS_START = 10'd35,
  parameter int         COLS        = 32'd80,
  parameter int         ROWS        = 32'd30,
  parameter logic [7:0] INIT_CHAR   = 8'h20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_en,
  input  logic [9:0]  h_cnt,
  input  logic [9:0]  v_cnt,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        wr_en,
  input  logic [11:0] wr_addr,
  input  logic [11:0] wr_data,
`ifdef CURSOR_BLINK_EN
  input  logic        cursor_en,
  input  logic [11:0] cursor_addr,
`endif
  output logic        ready,
  output logic [11:0] font_addr,
  input  logic [7:0]  font_data,
  output logic        HSync,
  output logic        VSync,
  output logic [3:0]  Red,
  output logic [3:0]  Green,
  output logic [3:0]  Blue
);

  localparam int          CELLS     = COLS * ROWS;
  localparam logic [11:0] LAST_CELL = 12'(CELLS - 32'd1);
  localparam logic [11:0] COLS_W    = 12'(COLS);
  localparam logic [10:0] X_SPAN    = 11'(COLS * 32'd8);
  localparam logic [10:0] Y_SPAN    = 11'(ROWS * 32'd16);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // Full-scale channel level when the pixel is lit and this channel's fg bit is set.
  function automatic logic [3:0] chan_level(input logic lit, input logic fg);
    if (lit && fg) return 4'hF;
    else return 4'h0;
  endfunction

  state_t      state_r, state_s;
  logic [11:0] ptr_r, ptr_s;
  logic        ready_r;

  logic [11:0] mem_r [0:CELLS-1];
  logic        we_s;
  logic [11:0] waddr_s, wdata_s;

  logic [9:0]  x_s, y_s;
  logic        vis_s;
  logic [11:0] cell_s;
  logic        cur_s;

  logic [11:0] rd_data_r;
  logic        vis1_r, vis2_r;
  logic [2:0]  xs1_r, xs2_r;
  logic [3:0]  ys1_r;
  logic        cur1_r, cur2_r;
  logic [3:0]  attr2_r;
  logic [11:0] font_addr_r;
  logic [2:0]  hs_r, vs_r;
  logic [3:0]  red_r, green_r, blue_r;
  logic        lit_s;
  logic [3:0]  red_s, green_s, blue_s;

  // Next-state logic: clear sequencer walks every cell once, then RUN forever.
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    case (state_r)
      ST_CLEAR: begin
        if (ptr_r == LAST_CELL) begin
          state_s = ST_RUN;
          ptr_s   = 12'd0;
        end else begin
          ptr_s = ptr_r + 12'd1;
        end
      end
      ST_RUN: begin
        state_s = ST_RUN;
      end
      default: begin
        state_s = ST_CLEAR;
        ptr_s   = 12'd0;
      end
    endcase
  end

  // FSM state, clear pointer and registered ready flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_CLEAR;
      ptr_r   <= 12'd0;
      ready_r <= 1'b0;
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      ready_r <= (state_s == ST_RUN);
    end
  end

  // RAM write-port mux: clear sequencer owns the port until RUN.
  always_comb begin
    we_s    = 1'b0;
    waddr_s = ptr_r;
    wdata_s = {4'b0111, INIT_CHAR};
    if (state_r == ST_CLEAR) begin
      we_s = 1'b1;
    end else begin
      we_s    = wr_en && (wr_addr <= LAST_CELL);
      waddr_s = wr_addr;
      wdata_s = wr_data;
    end
  end

  // Text RAM write port (any clk, independent of the pixel tick).
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_r[waddr_s] <= wdata_s;
    end
  end

  // Stage 1 address generation: screen coordinates and cell index.
  always_comb begin
    x_s    = h_cnt - H_VIS_START;
    y_s    = v_cnt - V_VIS_START;
    vis_s  = ({1'b0, h_cnt} >= {1'b0, H_VIS_START}) &&
             ({1'b0, h_cnt} <  ({1'b0, H_VIS_START} + X_SPAN)) &&
             ({1'b0, v_cnt} >= {1'b0, V_VIS_START}) &&
             ({1'b0, v_cnt} <  ({1'b0, V_VIS_START} + Y_SPAN));
    // Park the read address on cell 0 off-screen so it never leaves the array.
    if (vis_s) begin
      cell_s = ({7'd0, y_s[8:4]} * COLS_W) + {5'd0, x_s[9:3]};
    end else begin
      cell_s = 12'd0;
    end
  end

`ifdef CURSOR_BLINK_EN
  logic [4:0] frame_cnt_r;
  logic       vs_prev_r;

  // Frame counter: one count per rising edge of vsync_in seen on a pixel tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_r <= 5'd0;
      vs_prev_r   <= 1'b0;
    end else if (pix_en) begin
      vs_prev_r <= vsync_in;
      if (vsync_in && !vs_prev_r) begin
        frame_cnt_r <= frame_cnt_r + 5'd1;
      end
    end
  end

  assign cur_s = cursor_en && frame_cnt_r[4] && (cell_s == cursor_addr);
`else
  assign cur_s = 1'b0;
`endif

  // Stage 3 pixel decision: glyph bit (bit7 = leftmost) XOR inverse XOR cursor.
  always_comb begin
    lit_s   = vis2_r && (font_data[~xs2_r] ^ attr2_r[3] ^ cur2_r);
    red_s   = chan_level(lit_s, attr2_r[2]);
    green_s = chan_level(lit_s, attr2_r[1]);
    blue_s  = chan_level(lit_s, attr2_r[0]);
  end

  // Three-stage pixel pipeline and matching sync delay line, advanced on pix_en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_r   <= 12'd0;
      vis1_r      <= 1'b0;
      xs1_r       <= 3'd0;
      ys1_r       <= 4'd0;
      cur1_r      <= 1'b0;
      font_addr_r <= 12'd0;
      attr2_r     <= 4'd0;
      xs2_r       <= 3'd0;
      vis2_r      <= 1'b0;
      cur2_r      <= 1'b0;
      red_r       <= 4'd0;
      green_r     <= 4'd0;
      blue_r      <= 4'd0;
      hs_r        <= 3'd0;
      vs_r        <= 3'd0;
    end else if (pix_en) begin
      // S1: reads taken while clearing would see a half-cleared RAM, so the
      // visible flag is qualified with ready; RGB stays 0 until RUN.
      rd_data_r   <= mem_r[cell_s];
      vis1_r      <= vis_s && ready_r;
      xs1_r       <= x_s[2:0];
      ys1_r       <= y_s[3:0];
      cur1_r      <= cur_s;
      // S2
      font_addr_r <= {rd_data_r[7:0], ys1_r};
      attr2_r     <= rd_data_r[11:8];
      xs2_r       <= xs1_r;
      vis2_r      <= vis1_r;
      cur2_r      <= cur1_r;
      // S3
      red_r       <= red_s;
      green_r     <= green_s;
      blue_r      <= blue_s;
      hs_r        <= {hs_r[1:0], hsync_in};
      vs_r        <= {vs_r[1:0], vsync_in};
    end
  end

  assign ready     = ready_r;
  assign font_addr = font_addr_r;
  assign HSync     = hs_r[2];
  assign VSync     = vs_r[2];
  assign Red       = red_r;
  assign Green     = green_r;
  assign Blue      = blue_r;

endmodule

// File: tb/tb_vga_text_overlay.sv
// -----------------------------------------------------------------------------
// tb_vga_text_overlay
//   Self-checking bench for vga_text_overlay. A screen-level model (text array
//   plus a 3-entry delay of expected pixels/syncs) predicts ready, HSync, VSync
//   and RGB; a compare process checks them on every falling clk edge. A few
//   hand-computed pixel expectations pin the model itself.
// -----------------------------------------------------------------------------
module tb_vga_text_overlay;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        pix_en = 1'b0;
  logic [9:0]  h_cnt = 10'd0, v_cnt = 10'd0;
  logic        hsync_in = 1'b0, vsync_in = 1'b0;
  logic        wr_en = 1'b0;
  logic [11:0] wr_addr = 12'd0, wr_data = 12'd0;
  logic        ready;
  logic [11:0] font_addr;
  logic [7:0]  font_data = 8'd0;
  logic        HSync, VSync;
  logic [3:0]  Red, Green, Blue;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vga_text_overlay dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .h_cnt(h_cnt), .v_cnt(v_cnt),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef CURSOR_BLINK_EN
    .cursor_en(1'b0), .cursor_addr(12'd0),
`endif
    .ready(ready), .font_addr(font_addr), .font_data(font_data),
    .HSync(HSync), .VSync(VSync),
    .Red(Red), .Green(Green), .Blue(Blue)
  );

  // Font contents: 'A' row 0 = 8'h80, space is blank, everything else hashed.
  function automatic logic [7:0] font_fn(input logic [7:0] code, input logic [3:0] row);
    logic [7:0] t;
    if (code == 8'h41 && row == 4'd0) return 8'h80;
    if (code == 8'h20) return 8'h00;
    t = code * 8'd37;
    t = t + {row, row};
    return t ^ 8'h5A;
  endfunction

  // Font ROM: synchronous read, one clk latency.
  always @(posedge clk) font_data <= font_fn(font_addr[11:4], font_addr[3:0]);

  // ---------------- behavioural model ----------------
  logic [11:0] mem_m [0:2399];
  logic [13:0] e_q [0:2];   // {hsync, vsync, rgb}; e_q[2] is what the outputs show now
  logic        m_ready;
  int          clk_cnt;

  function automatic logic [11:0] pixel(input int h, input int v);
    int x, y;
    logic [11:0] c;
    logic [7:0]  g;
    logic        b;
    x = h - 144;
    y = v - 35;
    if (x < 0 || x >= 640 || y < 0 || y >= 480) return 12'h000;
    c = mem_m[(y / 16) * 80 + x / 8];
    g = font_fn(c[7:0], 4'(y % 16));
    b = g[7 - (x % 8)] ^ c[11];
    if (!b) return 12'h000;
    return {c[10] ? 4'hF : 4'h0, c[9] ? 4'hF : 4'h0, c[8] ? 4'hF : 4'h0};
  endfunction

  task automatic model_reset();
    clk_cnt = 0;
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) e_q[i] = 14'd0;
    for (int i = 0; i < 2400; i++) mem_m[i] = 12'h720;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        if (pix_en) begin
          e_q[2] = e_q[1];
          e_q[1] = e_q[0];
          e_q[0] = {hsync_in, vsync_in,
                    (clk_cnt >= 2400) ? pixel(int'(h_cnt), int'(v_cnt)) : 12'h000};
        end
        if (wr_en && clk_cnt >= 2400 && wr_addr < 12'd2400) mem_m[wr_addr] = wr_data;
        clk_cnt++;
        m_ready = (clk_cnt >= 2400);
      end
    end
  end

  // Cycle-by-cycle compare against the model.
  initial begin
    forever begin
      @(negedge clk);
      n_cmp++;
      if ({ready, HSync, VSync, Red, Green, Blue} !== {m_ready, e_q[2]}) begin
        n_fail++;
        $display("FAIL cycle t=%0t {ready,hs,vs,rgb} act=%b_%b_%b_%h exp=%b_%b_%b_%h", $time,
                 ready, HSync, VSync, {Red, Green, Blue},
                 m_ready, e_q[2][13], e_q[2][12], e_q[2][11:0]);
      end
    end
  end

  // ---------------- stimulus helpers (entered at posedge+1) ----------------
  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // One pixel period of 4 clks; an optional write lands on clk 'slot' (0 = with the tick).
  task automatic tick(input int h, input int v, input bit hs, input bit vs,
                      input bit we, input int wa, input logic [11:0] wd, input int slot);
    for (int k = 0; k < 4; k++) begin
      pix_en   = (k == 0);
      h_cnt    = 10'(h);
      v_cnt    = 10'(v);
      hsync_in = hs;
      vsync_in = vs;
      wr_en    = we && (k == slot);
      wr_addr  = 12'(wa);
      wr_data  = wd;
      @(posedge clk); #1;
    end
    pix_en = 1'b0;
    wr_en  = 1'b0;
  endtask

  task automatic wr(input int a, input logic [11:0] d);
    wr_en = 1'b1; wr_addr = 12'(a); wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic pin_px(input string nm, input int h, input int v, input logic [11:0] exp);
    tick(h, v, 1'b0, 1'b0, 1'b0, 0, 12'd0, 0);
    tick(0, 0, 1'b0, 1'b0, 1'b0, 0, 12'd0, 0);
    tick(0, 0, 1'b0, 1'b0, 1'b0, 0, 12'd0, 0);
    check(nm, int'({Red, Green, Blue}), int'(exp));
  endtask

  // Release reset and count falling edges with ready low; writes held on throughout.
  task automatic wait_clear(output int zeros);
    zeros   = 0;
    wr_en   = 1'b1;
    wr_addr = 12'd0;
    wr_data = 12'h741;
    rst_n   = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (ready) break;
      zeros++;
    end
    wr_en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic sweep_line(input int v, output int hs_hi);
    hs_hi = 0;
    for (int h = 0; h < 803; h++) begin
      if (h < 800) tick(h, v, (h < 96), 1'b0, 1'b0, 0, 12'd0, 0);
      else tick(0, v + 1, 1'b0, 1'b0, 1'b0, 0, 12'd0, 0);
      if (HSync) hs_hi++;
    end
  endtask

  // ---------------- main sequence ----------------
  int zeros, hs_hi, rh, rv, rwa, rslot;
  bit rwe;

  initial begin
    #1 rst_n = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("reset_ready", int'(ready), 0);
    check("reset_font_addr", int'(font_addr), 0);
    check("reset_outputs", int'({HSync, VSync, Red, Green, Blue}), 0);

    wait_clear(zeros);
    check("clear_len", zeros, 2400);
    check("ready_after_clear", int'(ready), 1);
    pin_px("cell0_cleared", 144, 35, 12'h000);

    wr(0, 12'h741);
    pin_px("A_left", 144, 35, 12'hFFF);
    pin_px("A_right", 145, 35, 12'h000);

    wr(2399, 12'hC41);
    pin_px("last_inv_red", 777, 499, 12'hF00);
    pin_px("last_inv_off", 776, 499, 12'h000);

    wr(2400, 12'h000);
    pin_px("oob_write_ignored", 144, 35, 12'hFFF);

    wr(79, 12'hF20);
    pin_px("inv_last_col", 783, 35, 12'hFFF);
    pin_px("right_blank", 784, 35, 12'h000);
    pin_px("left_blank", 143, 35, 12'h000);

    sweep_line(35, hs_hi);
    check("hsync_width_l35", hs_hi, 96);
    sweep_line(514, hs_hi);
    check("hsync_width_l514", hs_hi, 96);

    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(3, 0) != 0) begin
        rh = int'($urandom_range(783, 144));
        rv = int'($urandom_range(514, 35));
      end else begin
        rh = int'($urandom_range(799, 0));
        rv = int'($urandom_range(524, 0));
      end
      rwe   = ($urandom_range(2, 0) == 0);
      rslot = int'($urandom_range(3, 0));
      if ($urandom_range(7, 0) == 0) rwa = int'($urandom_range(2600, 2390));
      else rwa = int'($urandom_range(2399, 0));
      // Sometimes hit the cell being read on the same edge as the tick.
      if ($urandom_range(3, 0) == 0 && rh >= 144 && rh < 784 && rv >= 35 && rv < 515) begin
        rwa   = ((rv - 35) / 16) * 80 + (rh - 144) / 8;
        rslot = 0;
      end
      tick(rh, rv, $urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1,
           rwe, rwa, 12'($urandom), rslot);
    end

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midrun_reset_ready", int'(ready), 0);
    check("midrun_reset_font_addr", int'(font_addr), 0);
    wait_clear(zeros);
    check("clear_len_again", zeros, 2400);
    pin_px("cell0_recleared", 144, 35, 12'h000);
    for (int i = 0; i < 200; i++) begin
      tick(int'($urandom_range(799, 0)), int'($urandom_range(524, 0)),
           $urandom_range(1, 0) == 1, 1'b0, 1'b1, int'($urandom_range(2399, 0)),
           12'($urandom), int'($urandom_range(3, 0)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
